// File: rtl/uart_pkg.sv
// Shared UART definitions: parity and state encodings plus bit-timing helpers.
// Imported by the serializer now and by the receiver later.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Rounded to the nearest whole clock so the line rate error stays below half a clock per bit.
  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  function automatic int frame_len(input int parity, input int stop_bits);
    return 9 + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte strobe from the transmit sequencer plus the serial line and frame status back to it.
// The sequencer is the master; the serializer is the slave.
interface uart_byte_tx_if;
  logic       send_en;
  logic [7:0] data_byte;
  logic       uart_tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output send_en,
    output data_byte,
    input  uart_tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  send_en,
    input  data_byte,
    output uart_tx,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..DIV-1 while enabled and flags the final count with o_bit_end.
// Synchronous clear holds it at zero between frames; no backpressure.
module uart_baud_cnt #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bit_end
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_bit_end = i_en && (r_cnt == LAST);
endmodule

// File: rtl/uart_byte_tx.sv
// Single-byte UART serializer: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Line goes low the cycle after an accepted send_en; send_en while busy is dropped, never queued.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic           clk,
  input logic           rst,
  uart_byte_tx_if.slave bus
);
  localparam int         BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  if (BAUD_DIV < 2) begin : g_div_check
    $error("uart_byte_tx: BAUD_DIV must be at least 2");
  end

  state_t     r_state, w_state_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
  logic       r_par, w_par_nxt;
  logic       r_tx, w_tx_nxt;
  logic       r_busy;
  logic       r_done, w_done_nxt;
  logic       w_idle;
  logic       w_bit_end;

  assign w_idle = (r_state == ST_IDLE);

  uart_baud_cnt #(.DIV(BAUD_DIV)) u_baud (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_idle),
    .i_en      (!w_idle),
    .o_bit_end (w_bit_end)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_par_nxt     = r_par;
    w_done_nxt    = 1'b0;
    w_tx_nxt      = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (bus.send_en) begin
          w_state_nxt   = ST_START;
          w_shift_nxt   = bus.data_byte;
          w_bit_cnt_nxt = '0;
          w_par_nxt     = (PARITY == PAR_ODD) ? ~^bus.data_byte : ^bus.data_byte;
        end
      end
      ST_START: begin
        if (w_bit_end) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 4'd7) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_bit_cnt == STOP_LAST) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
            w_done_nxt    = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Line level is registered from the next state so it changes on the same edge as the FSM.
    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
      ST_PARITY: w_tx_nxt = w_par_nxt;
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_par     <= w_par_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_nxt;
    end
  end

  assign bus.uart_tx = r_tx;
  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;
endmodule
